// File: rtl/chol_inv_sqrt.sv
// Iterative reciprocal square root for unsigned Q16.16 operands: normalise, LUT seed,
// Newton-Raphson refinement in Q2.30 on one shared multiplier, then denormalise to Q16.16.
module chol_inv_sqrt #(
  parameter int ITER     = 3,
  parameter int LUT_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        data_valid,
  input  logic [31:0] data,
  output logic [31:0] out,
  output logic        out_valid
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_NORM   = 3'd1;
  localparam logic [2:0] S_SEED   = 3'd2;
  localparam logic [2:0] S_ITER   = 3'd3;
  localparam logic [2:0] S_DENORM = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int LUT_N = 1 << (LUT_BITS + 1);
  localparam int PW    = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(ITER - 1);
  localparam logic [31:0]   THREE_Q30 = 32'hC000_0000;

  // Seed = 1/sqrt of the interval midpoint, found by bisection at elaboration time.
  // Index MSB selects m in [2,4) versus [1,2); the low bits are mantissa bits below the leading one.
  function automatic logic [31:0] seed_calc(input int idx);
    logic [127:0] mm;
    logic [127:0] target;
    logic [31:0]  y;
    logic [31:0]  trial;
    int           par;
    int           frac;
    par    = (idx >> LUT_BITS) & 1;
    frac   = idx & ((1 << LUT_BITS) - 1);
    mm     = 128'((1 << (LUT_BITS + 1)) + 2 * frac + 1);
    if (par != 0) mm = mm << 1;
    target = 128'(1) << (61 + LUT_BITS);
    y      = 32'd0;
    for (int b = 31; b >= 0; b--) begin
      trial = y | (32'd1 << b);
      if (128'(trial) * 128'(trial) * mm <= target) y = trial;
    end
    return y;
  endfunction

  function automatic logic [31:0] round_sat(input logic [31:0] val, input logic [4:0] sh);
    logic [32:0] acc;
    acc = ({1'b0, val} + (33'd1 << (sh - 5'd1))) >> sh;
    return acc[32] ? 32'hFFFF_FFFF : acc[31:0];
  endfunction

  logic [2:0]        state;
  logic [1:0]        sub;
  logic [PW-1:0]     pass;
  logic [31:0]       x_reg;
  logic [31:0]       m_reg;
  logic [31:0]       y_reg;
  logic [31:0]       t_reg;
  logic [LUT_BITS:0] idx_reg;
  logic [4:0]        sh_reg;
  logic              zero_reg;
  logic [31:0]       res_reg;

  logic [31:0]       lut [LUT_N];
  logic [4:0]        lead;
  logic [31:0]       norm;
  logic [31:0]       mul_a;
  logic [31:0]       mul_b;
  logic [63:0]       prod;
  logic              prod_unused;

  for (genvar i = 0; i < LUT_N; i++) begin : g_lut
    assign lut[i] = seed_calc(i);
  end

  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (x_reg[i]) lead = 5'(i);
    end
  end

  // Leading one lands on bit 31; an even position is shifted down once so the exponent stays even.
  assign norm = x_reg << (5'd31 - lead);

  always_comb begin
    mul_a = y_reg;
    mul_b = y_reg;
    case (sub)
      2'd1: begin
        mul_a = m_reg;
        mul_b = t_reg;
      end
      2'd2: begin
        mul_a = y_reg;
        mul_b = THREE_Q30 - t_reg;
      end
      default: ;
    endcase
  end

  assign prod        = {32'd0, mul_a} * {32'd0, mul_b};
  assign prod_unused = ^{prod[63], prod[29:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      sub       <= 2'd0;
      pass      <= '0;
      out       <= 32'd0;
      out_valid <= 1'b0;
    end else if (clken) begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE:   if (data_valid) state <= S_NORM;
        S_NORM:   state <= S_SEED;
        S_SEED: begin
          state <= S_ITER;
          sub   <= 2'd0;
          pass  <= '0;
        end
        S_ITER: begin
          if (sub == 2'd2) begin
            sub <= 2'd0;
            if (pass == LAST_PASS) state <= S_DENORM;
            else                   pass  <= pass + 1'b1;
          end else begin
            sub <= sub + 2'd1;
          end
        end
        S_DENORM: state <= S_DONE;
        S_DONE: begin
          out       <= res_reg;
          out_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Datapath: no reset needed, every value is rewritten before it is consumed.
  always_ff @(posedge clk) begin
    if (clken) begin
      case (state)
        S_IDLE: if (data_valid) x_reg <= data;
        S_NORM: begin
          m_reg    <= lead[0] ? norm : (norm >> 1);
          idx_reg  <= {lead[0], norm[30 -: LUT_BITS]};
          sh_reg   <= 5'd6 + {1'b0, lead[4:1]};
          zero_reg <= (x_reg == 32'd0);
        end
        S_SEED: y_reg <= lut[idx_reg];
        S_ITER: begin
          case (sub)
            2'd0, 2'd1: t_reg <= prod[61:30];
            2'd2:       y_reg <= prod[62:31];
            default: ;
          endcase
        end
        S_DENORM: res_reg <= zero_reg ? 32'hFFFF_FFFF : round_sat(y_reg, sh_reg);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chol_inv_sqrt.sv
// Self-checking bench for chol_inv_sqrt: directed cases plus random operands against a
// real-arithmetic reference of 65536/sqrt(x_real).
module tb_chol_inv_sqrt;

  logic        clk = 1'b0;
  logic        rst;
  logic        clken;
  logic        data_valid;
  logic [31:0] data;
  logic [31:0] out;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  chol_inv_sqrt #(.ITER(3), .LUT_BITS(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .clken     (clken),
    .data_valid(data_valid),
    .data      (data),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_rsqrt(input logic [31:0] x);
    real r;
    if (x == 32'd0) return 32'hFFFF_FFFF;
    r = 16777216.0 / $sqrt(real'(x));
    return 32'($rtoi(r + 0.5));
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic check_tol(input string tag, input logic [31:0] obs, input logic [31:0] expv,
                           input int tol);
    longint d;
    logic   near;
    d = longint'(obs) - longint'(expv);
    if (d < 0) d = -d;
    near = (d <= longint'(tol));
    checks++;
    assert (near === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h +/-%0d", tag, obs, expv, tol);
    end
  endtask

  // One request: data_valid high for 'hold' edges, optional busy-time request and clken stall.
  task automatic run_op(input logic [31:0] x, input logic [31:0] expv, input int tol,
                        input int hold, input int busy_at, input logic [31:0] busy_data,
                        input int stall_at, input int stall_len, input string tag);
    int          cyc;
    int          lat;
    int          pulses;
    logic [31:0] got;
    data       = x;
    data_valid = 1'b1;
    clken      = 1'b1;
    @(posedge clk); #1;
    cyc    = 0;
    lat    = -1;
    pulses = 0;
    got    = 32'd0;
    while (cyc < 40) begin
      data_valid = (cyc + 1 < hold) || (cyc == busy_at);
      if (cyc == busy_at) data = busy_data;
      clken = !(stall_len > 0 && cyc >= stall_at && cyc < stall_at + stall_len);
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = cyc;
          got = out;
        end
      end
    end
    data_valid = 1'b0;
    clken      = 1'b1;
    check_eq({tag, "_latency"}, 32'(lat), 32'(13 + stall_len));
    check_eq({tag, "_pulses"}, 32'(pulses), 32'd1);
    check_tol({tag, "_value"}, got, expv, tol);
    check_eq({tag, "_hold"}, out, got);
  endtask

  initial begin
    int          pulses;
    logic [31:0] x;

    rst        = 1'b0;
    clken      = 1'b1;
    data_valid = 1'b0;
    data       = 32'd0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check_eq("reset_out", out, 32'd0);
    check_eq("reset_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(32'h0002_0000, 32'h0000_B505, 2, 4, -1, 32'd0, 0, 0, "two_held");
    run_op(32'h00C1_3F9C, 32'h0000_126A, 2, 1, -1, 32'd0, 0, 0, "x193");
    run_op(32'h0001_0000, 32'h0001_0000, 1, 1, -1, 32'd0, 0, 0, "one");
    run_op(32'h0004_0000, 32'h0000_8000, 1, 1, -1, 32'd0, 0, 0, "four");
    run_op(32'h0000_4000, 32'h0002_0000, 1, 1, -1, 32'd0, 0, 0, "quarter");
    run_op(32'h0000_0001, 32'h0100_0000, 2, 1, -1, 32'd0, 0, 0, "min");
    run_op(32'hFFFF_FFFF, 32'h0000_0100, 2, 1, -1, 32'd0, 0, 0, "max");
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 0, 1, -1, 32'd0, 0, 0, "zero");
    run_op(32'h0009_0000, ref_rsqrt(32'h0009_0000), 2, 1, 5, 32'h0000_0100, 0, 0, "busy");
    run_op(32'h0010_0000, ref_rsqrt(32'h0010_0000), 2, 1, -1, 32'd0, 5, 5, "stall");

    // Reset mid-computation, with clken low to show reset does not depend on it.
    data       = 32'h0003_0000;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst   = 1'b0;
    clken = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst    = 1'b1;
    clken  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check_eq("midreset_pulses", 32'(pulses), 32'd0);
    check_eq("midreset_out", out, 32'd0);
    run_op(32'h0003_0000, ref_rsqrt(32'h0003_0000), 2, 1, -1, 32'd0, 0, 0, "after_reset");

    for (int i = 0; i < 16; i++) begin
      x = $urandom >> $urandom_range(0, 31);
      run_op(x, ref_rsqrt(x), (x == 32'd0) ? 0 : 2, 1, -1, 32'd0, 0, 0,
             $sformatf("rand%0d_%08h", i, x));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chol_inv_sqrt.md
Name: chol_inv_sqrt

Overview:
Computes the reciprocal square root y = 1/sqrt(x) of an unsigned Q16.16 fixed-point operand. It is the diagonal-normalisation stage of the Cholesky decomposition datapath. It is an iterative, single-issue unit: normalise the operand, seed from a small LUT, refine with Newton-Raphson, then denormalise to Q16.16. Result is flagged by a one-cycle out_valid pulse.

Parameters:
ITER, 3, number of Newton-Raphson refinement passes (each 3 cycles); latency = 4 + 3*ITER.
LUT_BITS, 4, mantissa bits (below the leading one) indexing the seed LUT.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous reset, active-low (rst==0 at a rising edge resets).
clken  input  1  clock enable; when 0 every register, including outputs, holds.
data_valid  input  1  request strobe; operand sampled when high and unit idle.
data  input  32  operand x, unsigned Q16.16.
out  output  32  result 1/sqrt(x), unsigned Q16.16.
out_valid  output  1  one-cycle pulse: out holds a new result.

Behaviour:
- Reset (rst==0 at rising edge, regardless of clken): out=0, out_valid=0, FSM->IDLE; any in-flight computation aborted, no result emitted.
- All non-reset state advances only on edges with clken=1. clken=0 freezes everything; an out_valid pulse is stretched accordingly.
- FSM states: IDLE, NORM, SEED, ITER (ITER passes x 3 sub-steps), DENORM, DONE.
- Accept: edge where state==IDLE, clken=1, data_valid=1 -> capture data, go to NORM. data_valid is ignored in every other state (no queueing). If data_valid is still high when the unit returns to IDLE, a new operation starts.
- NORM: leading-one position p of x. Mantissa m in [1,4) with even exponent e, such that x = m*2^e.
- SEED: LUT indexed by the LUT_BITS below the leading one plus the parity bit. Gives an estimate of 1/sqrt(m) in internal Q2.30.
- ITER sub-steps, all Q2.30 with truncation of products:
  - t = y*y
  - t = m*t
  - y = y*(3 - t)/2
- DENORM: y * 2^(-e/2), rounded half-up to Q16.16, saturated to 0xFFFF_FFFF.
- DONE: register out, pulse out_valid, return to IDLE.
- Latency: out and out_valid update exactly 4+3*ITER = 13 enabled edges after the accept edge. out_valid is high for exactly one enabled cycle.
- out holds the last result until the next result or reset.
- Accuracy: |out - round(65536/sqrt(x_real))| <= 2 LSB for every nonzero x.
- x == 0: out=0xFFFF_FFFF, same latency, out_valid pulses normally.
- Range: minimum x=0x0000_0001 gives 0x0100_0000. Maximum x=0xFFFF_FFFF gives 0x0000_0100 (±2 LSB). No internal overflow is permitted anywhere in this range.
- Multiplications are 32x32 signed/unsigned products. Synthesis may map them to DSP blocks; one multiplier may be shared across sub-steps.

Test Plan:
- Reset held low several cycles -> out=0, out_valid=0. Release, data=0x0002_0000 (2.0), data_valid high 4 cycles -> exactly one out_valid pulse, 13 edges after first accept, out=0x0000_B505 ±2.
- data=0x00C1_3F9C (193.2484741) pulsed -> single result, out=0x0000_126A ±2; out holds value after pulse.
- Exact powers: 1.0 (0x0001_0000) -> 0x0001_0000. 4.0 -> 0x0000_8000. 0.25 (0x0000_4000) -> 0x0002_0000. All exact ±1.
- Extremes: x=0x0000_0001 -> 0x0100_0000 ±2. x=0xFFFF_FFFF -> 0x0000_0100 ±2. x=0 -> 0xFFFF_FFFF.
- Busy handling: new data_valid with a different operand mid-computation -> ignored, first result unchanged. clken low for 5 cycles mid-run -> result delayed exactly 5 cycles, value unchanged.
- Reset asserted mid-computation -> no out_valid pulse, out=0. Next request completes correctly.
